// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: opcode map, fetch FSM states
// and instruction field geometry.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_BNE   = 4'h3;
    localparam logic [3:0] OP_BLT   = 4'h4;
    localparam logic [3:0] OP_BGT   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_END   = 4'hF;

    // Opcode sits in the top nibble, func3 directly below it.
    localparam int OPCODE_W = 4;
    localparam int FUNC3_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic is_end_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_END);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for the fetch unit: DEPTH entries of WIDTH bits with
// push, pop, synchronous flush and an occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;

    // Qualify pop/push so an empty pop or an overfull push cannot corrupt state.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && (count_r != CNT_W'(0))) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && ((count_r < CNT_W'(DEPTH)) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy; flush drops everything but leaves data words.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else if (flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to instruction memory, buffers
// responses in a prefetch FIFO and hands them to the control path.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic [3:0]         ir_opcode,
    output logic [2:0]         ir_func3,
    output logic               halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = INSTR_W + ADDR_W;

    fetch_state_t       state_r;
    fetch_state_t       state_s;
    logic [ADDR_W-1:0]  fetch_pc_r;
    logic               imem_en_r;
    logic [ADDR_W-1:0]  imem_addr_r;

    logic [CNT_W-1:0]   fifo_count_s;
    logic [ENT_W-1:0]   fifo_head_s;
    logic [INSTR_W-1:0] head_data_s;
    logic [ADDR_W-1:0]  head_pc_s;
    logic               head_valid_s;
    logic               pop_s;
    logic               push_s;
    logic               redirect_take_s;
    logic               resp_end_s;
    logic               head_end_s;
    logic [CNT_W:0]     committed_s;
    logic               room_s;
    logic               issue_s;

    // A request issued on the previous edge returns its word during the
    // current cycle, so imem_en_r doubles as the in-flight flag. A redirect
    // on that same edge kills the response simply by suppressing its push.
    assign head_data_s     = fifo_head_s[ENT_W-1 -: INSTR_W];
    assign head_pc_s       = fifo_head_s[ADDR_W-1:0];
    assign head_valid_s    = (fifo_count_s != CNT_W'(0));
    assign pop_s           = head_valid_s && ir_ready;
    assign redirect_take_s = redirect_valid && (state_r != HALTED);
    assign push_s          = imem_en_r && !redirect_take_s;
    assign resp_end_s      = is_end_op(imem_rdata[INSTR_W-1 -: OPCODE_W]);
    assign head_end_s      = is_end_op(head_data_s[INSTR_W-1 -: OPCODE_W]);

    // Reservation: entries left after this edge's pop plus the word arriving now.
    assign committed_s = {1'b0, fifo_count_s} - (CNT_W + 1)'(pop_s) + (CNT_W + 1)'(imem_en_r);
    assign room_s      = (committed_s < (CNT_W + 1)'(DEPTH));

    // Issue decision; an END word arriving now stops the next request.
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == RUN) && !redirect_valid && room_s
            && !(imem_en_r && resp_end_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic for the fetch FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                state_s = RUN;
            end
            RUN: begin
                if (redirect_take_s) begin
                    state_s = RUN;
                end else if (push_s && resp_end_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (redirect_take_s) begin
                    state_s = RUN;
                end else if (pop_s && head_end_s) begin
                    state_s = HALTED;
                end else begin
                    state_s = DRAIN;
                end
            end
            HALTED: begin
                state_s = HALTED;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, PC and the registered memory request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            fetch_pc_r  <= RESET_PC;
            imem_en_r   <= 1'b0;
            imem_addr_r <= ADDR_W'(0);
        end else begin
            state_r   <= state_s;
            imem_en_r <= issue_s;
            if (redirect_take_s) begin
                fetch_pc_r <= redirect_pc;
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + ADDR_W'(1);
            end
            if (issue_s) begin
                imem_addr_r <= fetch_pc_r;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data ({imem_rdata, imem_addr_r}),
        .pop       (pop_s),
        .flush     (redirect_take_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    assign imem_en   = imem_en_r;
    assign imem_addr = imem_addr_r;
    assign ir_valid  = head_valid_s;
    assign ir_data   = head_data_s;
    assign ir_pc     = head_pc_s;
    assign ir_opcode = head_data_s[INSTR_W-1 -: OPCODE_W];
    assign ir_func3  = head_data_s[INSTR_W-1-OPCODE_W -: FUNC3_W];
    assign halted    = (state_r == HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance from PC 0, one from PC 8'hFE
// sharing inputs and an instruction memory image.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        ir_ready;
    logic [15:0] mem [256];

    logic        a_en, a_valid, a_halted, b_en, b_valid, b_halted;
    logic [7:0]  a_addr, a_pc, b_addr, b_pc;
    logic [15:0] a_rdata, a_data, b_rdata, b_data;
    logic [3:0]  a_op, b_op;
    logic [2:0]  a_f3, b_f3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // imem_addr is the memory's address register: the word is on imem_rdata
    // during the cycle imem_en is high and is captured at the following edge.
    assign a_rdata = mem[a_addr];
    assign b_rdata = mem[b_addr];

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .imem_en(a_en), .imem_addr(a_addr),
        .imem_rdata(a_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(a_valid), .ir_ready(ir_ready), .ir_data(a_data), .ir_pc(a_pc),
        .ir_opcode(a_op), .ir_func3(a_f3), .halted(a_halted)
    );

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .DEPTH(2), .RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .imem_en(b_en), .imem_addr(b_addr),
        .imem_rdata(b_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(b_valid), .ir_ready(ir_ready), .ir_data(b_data), .ir_pc(b_pc),
        .ir_opcode(b_op), .ir_func3(b_f3), .halted(b_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [7:0] pc,
                            input logic [15:0] data, input logic [7:0] exp_pc,
                            input logic [15:0] exp_data);
        chk({tag, "_valid"}, 32'(v), 32'd1);
        chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, "_data"}, 32'(data), 32'(exp_data));
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic fill_mem;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h1000 | 16'(i);
        end
    endtask

    // Two reset edges, check the cleared state, release with the given ready.
    task automatic do_reset(input logic rdy);
        tick;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        ir_ready       = 1'b0;
        tick;
        tick;
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_en", 32'(a_en), 32'd0);
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_pc", 32'(a_pc), 32'd0);
        chk("rst_halted", 32'(a_halted), 32'd0);
        chk("rst_wrap_addr", 32'(b_addr), 32'd0);
        reset_n  = 1'b1;
        ir_ready = rdy;
    endtask

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        ir_ready       = 1'b0;
        fill_mem();

        // Sequential stream at full rate.
        do_reset(1'b1);
        tick;
        chk("seq_idle_en", 32'(a_en), 32'd0);
        tick;
        chk("seq_first_en", 32'(a_en), 32'd1);
        chk("seq_first_addr", 32'(a_addr), 32'd0);
        chk("seq_first_valid", 32'(a_valid), 32'd0);
        for (int p = 0; p < 6; p++) begin
            tick;
            chk_head("seq", a_valid, a_pc, a_data, 8'(p), 16'h1000 | 16'(p));
            chk("seq_en", 32'(a_en), 32'd1);
        end

        // Backpressure from the first word.
        do_reset(1'b0);
        tick;
        tick;
        tick;
        chk_head("bp_first", a_valid, a_pc, a_data, 8'h00, 16'h1000);
        chk("bp_addr1", 32'(a_addr), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick;
            chk_head("bp_hold", a_valid, a_pc, a_data, 8'h00, 16'h1000);
            chk("bp_en_off", 32'(a_en), 32'd0);
        end
        ir_ready = 1'b1;
        tick;
        chk_head("bp_resume1", a_valid, a_pc, a_data, 8'h01, 16'h1001);
        chk("bp_resume_en", 32'(a_en), 32'd1);
        chk("bp_resume_addr", 32'(a_addr), 32'd2);
        tick;
        chk_head("bp_resume2", a_valid, a_pc, a_data, 8'h02, 16'h1002);
        tick;
        chk_head("bp_resume3", a_valid, a_pc, a_data, 8'h03, 16'h1003);

        // Redirect while the pc 3 request is in flight, head not consumed.
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) tick;
        chk_head("rd_pre", a_valid, a_pc, a_data, 8'h02, 16'h1002);
        chk("rd_pre_addr", 32'(a_addr), 32'd3);
        ir_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick;
        chk("rd_flush_valid", 32'(a_valid), 32'd0);
        chk("rd_flush_en", 32'(a_en), 32'd0);
        redirect_valid = 1'b0;
        ir_ready       = 1'b1;
        tick;
        chk("rd_issue_valid", 32'(a_valid), 32'd0);
        chk("rd_issue_en", 32'(a_en), 32'd1);
        chk("rd_issue_addr", 32'(a_addr), 32'h40);
        tick;
        chk_head("rd_target", a_valid, a_pc, a_data, 8'h40, 16'h1040);
        tick;
        chk_head("rd_next", a_valid, a_pc, a_data, 8'h41, 16'h1041);

        // Redirect on the same edge that pc 2 is dequeued.
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) tick;
        chk_head("rdq_pre", a_valid, a_pc, a_data, 8'h02, 16'h1002);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        tick;
        chk("rdq_no_dup", 32'(a_valid), 32'd0);
        redirect_valid = 1'b0;
        tick;
        chk("rdq_issue_addr", 32'(a_addr), 32'h80);
        tick;
        chk_head("rdq_target", a_valid, a_pc, a_data, 8'h80, 16'h1080);
        tick;
        chk_head("rdq_next", a_valid, a_pc, a_data, 8'h81, 16'h1081);

        // END at pc 4, plus a func3-carrying word at pc 2.
        mem[2] = 16'h2A02;
        mem[4] = 16'hF000;
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) tick;
        chk_head("end_pc2", a_valid, a_pc, a_data, 8'h02, 16'h2A02);
        chk("end_opcode2", 32'(a_op), 32'h2);
        chk("end_func3", 32'(a_f3), 32'h5);
        tick;
        chk("end_issue4_en", 32'(a_en), 32'd1);
        chk("end_issue4_addr", 32'(a_addr), 32'd4);
        tick;
        chk_head("end_head", a_valid, a_pc, a_data, 8'h04, 16'hF000);
        chk("end_opcode", 32'(a_op), 32'hF);
        chk("end_no_issue", 32'(a_en), 32'd0);
        chk("end_not_halted", 32'(a_halted), 32'd0);
        tick;
        chk("end_halted", 32'(a_halted), 32'd1);
        chk("end_empty", 32'(a_valid), 32'd0);
        chk("end_en_off", 32'(a_en), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        tick;
        redirect_valid = 1'b0;
        chk("halt_redir_halted", 32'(a_halted), 32'd1);
        chk("halt_redir_en", 32'(a_en), 32'd0);
        tick;
        chk("halt_redir_en2", 32'(a_en), 32'd0);
        chk("halt_redir_valid", 32'(a_valid), 32'd0);
        chk("halt_redir_halted2", 32'(a_halted), 32'd1);
        fill_mem();

        // PC wrap from 8'hFE, then reset mid-stream.
        do_reset(1'b1);
        chk("wrap_rst_halted", 32'(a_halted), 32'd0);
        tick;
        tick;
        chk("wrap_first_addr", 32'(b_addr), 32'hFE);
        tick;
        chk_head("wrap_fe", b_valid, b_pc, b_data, 8'hFE, 16'h10FE);
        tick;
        chk_head("wrap_ff", b_valid, b_pc, b_data, 8'hFF, 16'h10FF);
        tick;
        chk_head("wrap_00", b_valid, b_pc, b_data, 8'h00, 16'h1000);
        tick;
        chk_head("wrap_01", b_valid, b_pc, b_data, 8'h01, 16'h1001);
        reset_n = 1'b0;
        tick;
        chk("mid_rst_valid", 32'(b_valid), 32'd0);
        chk("mid_rst_halted", 32'(b_halted), 32'd0);
        chk("mid_rst_en", 32'(b_en), 32'd0);
        chk("mid_rst_addr", 32'(b_addr), 32'd0);
        reset_n = 1'b1;
        tick;
        chk("mid_idle_en", 32'(b_en), 32'd0);
        tick;
        chk("mid_restart_en", 32'(b_en), 32'd1);
        chk("mid_restart_addr", 32'(b_addr), 32'hFE);
        tick;
        chk_head("mid_restart", b_valid, b_pc, b_data, 8'hFE, 16'h10FE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream fetch stage for the multicycle core's control path. Owns the program counter and issues word reads to the synchronous instruction memory. Buffers returned words in a small prefetch FIFO and presents them with a valid/ready handshake to the control path/IR. Accepts branch redirects, which flush the FIFO, and stops fetching after the END opcode.

Parameters:
ADDR_W, 8, instruction memory word-address width; PC wraps modulo 2^ADDR_W
INSTR_W, 16, instruction word width; opcode = [INSTR_W-1 -: 4], func3 = next 3 bits
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
imem_en  out  1  instruction memory read strobe
imem_addr  out  ADDR_W  read word address
imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_en
redirect_valid  in  1  branch taken; flush and restart at redirect_pc
redirect_pc  in  ADDR_W  redirect target
ir_valid  out  1  FIFO head is valid
ir_ready  in  1  consumer takes head this cycle
ir_data  out  INSTR_W  head instruction word
ir_pc  out  ADDR_W  address of head instruction
ir_opcode  out  4  head opcode field (combinational from ir_data)
ir_func3  out  3  head func3 field (combinational from ir_data)
halted  out  1  END instruction consumed; fetch stopped

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, fetch_pc=RESET_PC, FIFO empty, inflight=0, imem_en=0, imem_addr=0, ir_valid=0, ir_data=0, ir_pc=0, halted=0. Reset mid-operation discards FIFO contents and any in-flight response.
- FSM states: IDLE -> RUN unconditionally after 1 cycle. RUN -> DRAIN when a word with opcode 4'hF is written into the FIFO. DRAIN -> HALTED when the END word is dequeued (ir_valid & ir_ready). RUN/DRAIN -> RUN on redirect_valid. HALTED is sticky until reset; redirect is ignored there.
- Issue rule (RUN only): imem_en=1 when occupancy + inflight < DEPTH and redirect_valid=0. imem_addr=fetch_pc, registered, so imem_en and imem_addr change only at clk edges. fetch_pc increments by 1 per issue, wrapping 2^ADDR_W-1 -> 0. No issue in IDLE, DRAIN or HALTED.
- Response: one cycle after issue, imem_rdata and the issued address are pushed into the FIFO unless the request was killed. The occupancy reservation guarantees the push never overflows.
- Throughput: with ir_ready held at 1, one instruction per cycle after the initial 2-cycle latency. First ir_valid occurs 2 cycles after IDLE->RUN issue (issue edge + response edge).
- Dequeue: when ir_valid & ir_ready, the head pops. ir_data and ir_pc are FIFO head outputs, stable while ir_valid=1 and ir_ready=0.
- Redirect (redirect_valid=1 at a clk edge, not HALTED):
  - FIFO cleared, the in-flight response killed (kill flag / epoch bit), fetch_pc=redirect_pc, DRAIN cleared.
  - No issue in the redirect cycle. Issue from redirect_pc begins the next cycle.
  - ir_valid=0 the cycle after the redirect.
- Simultaneous redirect and dequeue: the dequeue completes (the consumer keeps the word), then the flush applies.
- Simultaneous push and pop on a full FIFO: legal, occupancy unchanged.
- Empty FIFO with ir_ready=1: no effect.
- Occupancy counter width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_RTYPE=4'h1, OP_ADDI=4'h2, OP_BNE=4'h3, OP_BLT=4'h4, OP_BGT=4'h5, OP_LOAD=4'h6, OP_STORE=4'h7, OP_END=4'hF);
  - fetch state enum {IDLE, RUN, DRAIN, HALTED};
  - field-slice localparams.
- One sub-module: fetch_fifo (parameterised DEPTH x (INSTR_W+ADDR_W), with push/pop/flush/count).

Test Plan:
- Sequential stream: imem[0..5]=ADD words, ir_ready=1 -> ir_pc sequence 0,1,2,3,4,5 on consecutive cycles after the first valid; imem_en never asserted with FIFO+inflight>=2.
- Backpressure: ir_ready=0 for 5 cycles -> FIFO holds pc 0,1; imem_en=0; ir_data/ir_pc stable; ir_ready=1 resumes with pc 1,2 in order.
- Redirect with in-flight request: redirect_pc=8'h40 while a request to pc 3 is outstanding -> pc 3 word never appears; next ir_pc=8'h40; ir_valid=0 for the cycle after redirect.
- Redirect coincident with dequeue of pc 2 -> pc 2 consumed once, next ir_pc=redirect target, no duplicate.
- END handling: imem[4]=16'hF000 -> no imem_en after the pc 4 issue. halted=1 the cycle after pc 4 is dequeued. Later redirect_valid is ignored and halted stays 1.
- Wrap and reset: RESET_PC=8'hFE -> ir_pc FE, FF, 00, 01. Assert reset_n=0 mid-stream -> next cycle ir_valid=0, halted=0, imem_en=0, and fetch restarts at FE.
